// File: rtl/alu_md.sv
// alu_md - registered EX-stage execution unit.
//   Base integer ops finish one cycle after accept. RV32M multiply and divide
//   iterate radix-2 over WIDTH cycles: shift-add for multiply, restoring
//   division for divide. Both work on operand magnitudes, and the sign is
//   applied when the op completes.
//   Divide-by-zero and signed overflow take a one-cycle fast path.
//
// Build option:
//   ALU_MD_FAST_MUL_EN  when defined, MUL/MULH/MULHSU/MULHU use a single-cycle
//                       2*WIDTH multiplier and take the base-op path.
//                       Divide stays iterative.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   flush_i       abort any in-flight op; a same-cycle accept is dropped
//   in_valid_i    op/operands valid
//   in_ready_o    unit accepts an op this cycle
//   op_i          5-bit opcode
//   operand_a_i   rs1 operand
//   operand_b_i   rs2/imm operand
//   out_valid_o   result valid (DONE state)
//   out_ready_i   consumer takes the result
//   result_o      result, held stable while out_valid_o && !out_ready_i
module alu_md #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW-1:0]   CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] accHi_q, accHi_d;
  logic [WIDTH-1:0] accLo_q, accLo_d;
  logic [WIDTH-1:0] operB_q, operB_d;
  logic [4:0]       op_q, op_d;
  logic             negQ_q, negQ_d;
  logic             negR_q, negR_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic             accept;
  logic             opIsMul, opIsDiv;
  logic             signedA, signedB, aNeg, bNeg;
  logic [WIDTH-1:0] aMag, bMag;
  logic             divByZero, divOverflow, iterative;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] baseResult, fastResult;

  logic             iterIsDiv;
  logic [WIDTH:0]   mulSum, divShift, divDiff;
  logic             divFits;
  logic [WIDTH-1:0] stepHi, stepLo;
  logic [2*WIDTH-1:0] prodFull, prodFix;
  logic [WIDTH-1:0] quotFix, remFix, iterResult;

  assign in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == DONE);
  assign result_o    = result_q;

  // Incoming op decode. Signedness is per operand: MULHSU treats rs1 as
  // signed and rs2 as unsigned. The iterative engines only ever see
  // magnitudes, so negative operands are negated here, and the signs of the
  // quotient/product and of the remainder are remembered for the fix-up at
  // completion.
  always_comb begin
    opIsMul = (op_i[4:2] == 3'b100);
    opIsDiv = (op_i[4:2] == 3'b101);
    signedA = 1'b0;
    signedB = 1'b0;
    if (opIsDiv) begin
      signedA = ~op_i[0];
      signedB = ~op_i[0];
    end else if (opIsMul) begin
      signedA = (op_i[1:0] != 2'b11);
      signedB = ~op_i[1];
    end
    aNeg        = signedA & operand_a_i[WIDTH-1];
    bNeg        = signedB & operand_b_i[WIDTH-1];
    aMag        = aNeg ? -operand_a_i : operand_a_i;
    bMag        = bNeg ? -operand_b_i : operand_b_i;
    divByZero   = (operand_b_i == '0);
    divOverflow = ~op_i[0] && (operand_a_i == MIN_NEG) && (operand_b_i == '1);
`ifdef ALU_MD_FAST_MUL_EN
    iterative   = opIsDiv && !divByZero && !divOverflow;
`else
    iterative   = opIsMul || (opIsDiv && !divByZero && !divOverflow);
`endif
  end

`ifdef ALU_MD_FAST_MUL_EN
  logic [2*WIDTH-1:0] mulWideA, mulWideB, mulWideP;

  // Single-cycle multiplier. Both operands are extended to 2*WIDTH, each
  // according to its own signedness, so that one unsigned 2*WIDTH multiply
  // yields the exact product modulo 2^(2*WIDTH) for every mul flavour.
  always_comb begin
    mulWideA = signedA ? {{WIDTH{operand_a_i[WIDTH-1]}}, operand_a_i}
                       : {{WIDTH{1'b0}}, operand_a_i};
    mulWideB = signedB ? {{WIDTH{operand_b_i[WIDTH-1]}}, operand_b_i}
                       : {{WIDTH{1'b0}}, operand_b_i};
    mulWideP = mulWideA * mulWideB;
  end
`endif

  // Base integer ALU. Opcodes that are not listed here, including the M
  // codes, produce 0. Shifts use only the low SHW bits of rs2.
  always_comb begin
    baseResult = '0;
    shamt      = operand_b_i[SHW-1:0];
    case (op_i)
      5'd0:    baseResult = operand_a_i + operand_b_i;
      5'd1:    baseResult = operand_a_i - operand_b_i;
      5'd2:    baseResult = operand_a_i << shamt;
      5'd3:    baseResult = {{(WIDTH-1){1'b0}}, $signed(operand_a_i) < $signed(operand_b_i)};
      5'd4:    baseResult = {{(WIDTH-1){1'b0}}, operand_a_i < operand_b_i};
      5'd5:    baseResult = operand_a_i ^ operand_b_i;
      5'd6:    baseResult = operand_a_i >> shamt;
      5'd7:    baseResult = $signed(operand_a_i) >>> shamt;
      5'd8:    baseResult = operand_a_i | operand_b_i;
      5'd9:    baseResult = operand_a_i & operand_b_i;
      5'd10:   baseResult = operand_b_i;
      default: baseResult = '0;
    endcase
  end

  // Result for any op that finishes one cycle after accept. For a divide this
  // is the divide-by-zero or signed-overflow answer. The value is ignored when
  // the op goes to the iterative engine instead.
  always_comb begin
    fastResult = baseResult;
    if (opIsDiv) begin
      if (divByZero) fastResult = op_i[1] ? operand_a_i : '1;
      else           fastResult = op_i[1] ? '0 : operand_a_i;
    end
`ifdef ALU_MD_FAST_MUL_EN
    else if (opIsMul) begin
      fastResult = (op_i[1:0] == 2'b00) ? mulWideP[WIDTH-1:0]
                                        : mulWideP[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // One radix-2 step of the iterative engine. {accHi, accLo} is shared:
  // - Multiply: accHi holds the partial product high half and accLo holds
  //   the multiplier, which is shifted out while product bits shift in.
  // - Divide: accHi holds the partial remainder and accLo holds the
  //   dividend, which is shifted out while quotient bits shift in.
  // The step that ends the op also applies the sign fix-up and selects the
  // half or the quotient/remainder to return.
  always_comb begin
    iterIsDiv = (op_q[4:2] == 3'b101);
    mulSum    = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, operB_q} : '0);
    divShift  = {accHi_q, accLo_q[WIDTH-1]};
    divDiff   = divShift - {1'b0, operB_q};
    divFits   = ~divDiff[WIDTH];
    if (iterIsDiv) begin
      stepHi = divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
      stepLo = {accLo_q[WIDTH-2:0], divFits};
    end else begin
      stepHi = mulSum[WIDTH:1];
      stepLo = {mulSum[0], accLo_q[WIDTH-1:1]};
    end
    prodFull = {stepHi, stepLo};
    prodFix  = negQ_q ? -prodFull : prodFull;
    quotFix  = negQ_q ? -stepLo : stepLo;
    remFix   = negR_q ? -stepHi : stepHi;
    if (iterIsDiv)
      iterResult = op_q[1] ? remFix : quotFix;
    else
      iterResult = (op_q[1:0] == 2'b00) ? prodFix[WIDTH-1:0] : prodFix[2*WIDTH-1:WIDTH];
  end

  // Next-state logic.
  // - BUSY runs exactly WIDTH steps; the counter counts down to 0.
  // - DONE holds the result until out_ready_i. If a new op arrives in the
  //   same cycle, the accept below overrides the return to IDLE, so back-to-
  //   back ops leave no bubble.
  // - A flush wins over everything, including an accept in the same cycle.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    accHi_d  = accHi_q;
    accLo_d  = accLo_q;
    operB_d  = operB_q;
    op_d     = op_q;
    negQ_d   = negQ_q;
    negR_d   = negR_q;
    cnt_d    = cnt_q;

    case (state_q)
      BUSY: begin
        accHi_d = stepHi;
        accLo_d = stepLo;
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = iterResult;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: ;
    endcase

    if (accept && !flush_i) begin
      op_d = op_i;
      if (iterative) begin
        state_d = BUSY;
        accHi_d = '0;
        accLo_d = aMag;
        operB_d = bMag;
        negQ_d  = aNeg ^ bNeg;
        negR_d  = aNeg;
        cnt_d   = '1;
      end else begin
        state_d  = DONE;
        result_d = fastResult;
      end
    end

    if (flush_i) state_d = IDLE;
  end

  // State and datapath registers. Reset is synchronous and clears everything,
  // so a reset in the middle of BUSY simply abandons the op.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      result_q <= '0;
      accHi_q  <= '0;
      accLo_q  <= '0;
      operB_q  <= '0;
      op_q     <= '0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      accHi_q  <= accHi_d;
      accLo_q  <= accLo_d;
      operB_q  <= operB_d;
      op_q     <= op_d;
      negQ_q   <= negQ_d;
      negR_q   <= negR_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md - directed self-checking bench for alu_md.
//   Instantiates a WIDTH=32 unit and a WIDTH=16 unit on a shared clock and
//   reset. Inputs are driven, and outputs sampled, on falling clock edges.
//   Expected latencies follow ALU_MD_FAST_MUL_EN when it is defined.
module tb_alu_md;

`ifdef ALU_MD_FAST_MUL_EN
  localparam int MUL_LAT   = 1;
  localparam int MUL_LAT16 = 1;
`else
  localparam int MUL_LAT   = 33;
  localparam int MUL_LAT16 = 17;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [4:0]  opCode = 5'd0;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [31:0] result;

  logic        s16Valid = 1'b0;
  logic        s16InReady;
  logic [4:0]  s16Op = 5'd0;
  logic [15:0] s16A = '0;
  logic [15:0] s16B = '0;
  logic        s16OutValid;
  logic        s16OutReady = 1'b0;
  logic [15:0] s16Result;

  int checks = 0;
  int errors = 0;

  alu_md #(.WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .op_i        (opCode),
    .operand_a_i (opA),
    .operand_b_i (opB),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .result_o    (result)
  );

  alu_md #(.WIDTH(16)) dut16 (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (1'b0),
    .in_valid_i  (s16Valid),
    .in_ready_o  (s16InReady),
    .op_i        (s16Op),
    .operand_a_i (s16A),
    .operand_b_i (s16B),
    .out_valid_o (s16OutValid),
    .out_ready_i (s16OutReady),
    .result_o    (s16Result)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Compares one observed value against its expected value and counts the result.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one op for one cycle; called at a falling edge with in_ready high.
  // The operands are scrambled afterwards to show they are sampled only at accept.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    inValid = 1'b1;
    opCode  = op;
    opA     = a;
    opB     = b;
    @(negedge clk);
    inValid = 1'b0;
    opCode  = 5'd31;
    opA     = 32'hDEADBEEF;
    opB     = 32'h0BADF00D;
  endtask

  // Counts cycles from accept to out_valid; stops at 40 so a missing result cannot hang the run.
  task automatic waitResult(output int lat);
    lat = 1;
    while (!outValid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Runs one op end to end and checks both its latency and its result.
  task automatic runOp(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int expLat);
    int lat;
    outReady = 1'b1;
    applyStimulus(op, a, b);
    waitResult(lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, " result"}, result, exp);
  endtask

  // Directed test sequence.
  initial begin
    int  lat16;
    logic sawValid;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset in_ready", 32'(inReady), 32'd1);
    checkOutput("reset out_valid", 32'(outValid), 32'd0);
    checkOutput("reset result", result, 32'h0);

    runOp("ADD", 5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1);
    runOp("SUB", 5'd1, 32'd5, 32'd7, 32'hFFFFFFFE, 1);
    runOp("SLL", 5'd2, 32'h1, 32'h21, 32'h2, 1);
    runOp("SRA", 5'd7, 32'h80000000, 32'h24, 32'hF8000000, 1);
    runOp("SRL", 5'd6, 32'h80000000, 32'd31, 32'h1, 1);
    runOp("SLT", 5'd3, 32'hFFFFFFFF, 32'h1, 32'h1, 1);
    runOp("SLTU", 5'd4, 32'hFFFFFFFF, 32'h1, 32'h0, 1);
    runOp("XOR", 5'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
    runOp("OR", 5'd8, 32'hF0, 32'h0F, 32'hFF, 1);
    runOp("AND", 5'd9, 32'hF0, 32'h3C, 32'h30, 1);
    runOp("PASS", 5'd10, 32'h1, 32'h12345678, 32'h12345678, 1);
    runOp("undef op11", 5'd11, 32'd5, 32'd6, 32'h0, 1);
    runOp("undef op24", 5'd24, 32'd5, 32'd6, 32'h0, 1);

    runOp("MULH", 5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, MUL_LAT);
    runOp("MULHU", 5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    runOp("MUL", 5'd16, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
    runOp("MULHSU", 5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);

    runOp("DIV", 5'd20, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, DIV_LAT);
    runOp("REM", 5'd22, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, DIV_LAT);
    runOp("DIVU", 5'd21, 32'd100, 32'd7, 32'd14, DIV_LAT);
    runOp("REMU", 5'd23, 32'd100, 32'd7, 32'd2, DIV_LAT);
    runOp("DIVU by 0", 5'd21, 32'd100, 32'd0, 32'hFFFFFFFF, 1);
    runOp("REMU by 0", 5'd23, 32'd100, 32'd0, 32'd100, 1);
    runOp("DIV ovf", 5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    runOp("REM ovf", 5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);

    // Backpressure: the result must hold while the consumer stalls.
    @(negedge clk);
    outReady = 1'b0;
    applyStimulus(5'd0, 32'd10, 32'd20);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall out_valid", 32'(outValid), 32'd1);
      checkOutput("stall result", result, 32'd30);
      checkOutput("stall in_ready", 32'(inReady), 32'd0);
      @(negedge clk);
    end
    outReady = 1'b1;
    inValid  = 1'b1;
    opCode   = 5'd0;
    opA      = 32'd2;
    opB      = 32'd3;
    #1;
    checkOutput("b2b in_ready", 32'(inReady), 32'd1);
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("b2b out_valid", 32'(outValid), 32'd1);
    checkOutput("b2b result", result, 32'd5);
    @(negedge clk);
    checkOutput("b2b drain", 32'(outValid), 32'd0);

    // A flush in the same cycle as an accept drops that accept.
    inValid = 1'b1;
    opCode  = 5'd0;
    opA     = 32'd1;
    opB     = 32'd1;
    flush   = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    flush   = 1'b0;
    checkOutput("flush accept out_valid", 32'(outValid), 32'd0);
    checkOutput("flush accept in_ready", 32'(inReady), 32'd1);

    // A flush 10 cycles into a divide abandons the divide.
    applyStimulus(5'd21, 32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) begin
      checkOutput("busy out_valid", 32'(outValid), 32'd0);
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush in_ready", 32'(inReady), 32'd1);
    checkOutput("flush out_valid", 32'(outValid), 32'd0);
    sawValid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (outValid) sawValid = 1'b1;
    end
    checkOutput("flush no result", 32'(sawValid), 32'd0);
    runOp("ADD after flush", 5'd0, 32'd4, 32'd5, 32'd9, 1);

    // A reset in the middle of a multiply abandons it.
    applyStimulus(5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid reset out_valid", 32'(outValid), 32'd0);
    checkOutput("mid reset result", result, 32'h0);
    checkOutput("mid reset in_ready", 32'(inReady), 32'd1);
    sawValid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (outValid) sawValid = 1'b1;
    end
    checkOutput("mid reset no result", 32'(sawValid), 32'd0);

    // The WIDTH=16 unit: MULHU 0xFFFF * 0xFFFF has high half 0xFFFE.
    checkOutput("w16 in_ready", 32'(s16InReady), 32'd1);
    s16OutReady = 1'b1;
    s16Valid    = 1'b1;
    s16Op       = 5'd19;
    s16A        = 16'hFFFF;
    s16B        = 16'hFFFF;
    @(negedge clk);
    s16Valid = 1'b0;
    s16A     = 16'h1234;
    s16B     = 16'h0000;
    lat16    = 1;
    while (!s16OutValid && lat16 < 30) begin
      @(negedge clk);
      lat16++;
    end
    checkOutput("w16 MULHU latency", 32'(lat16), 32'(MUL_LAT16));
    checkOutput("w16 MULHU result", {16'h0, s16Result}, 32'h0000FFFE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
